// File: rtl/sha256_pkg.sv
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 types, round constants, IV and word helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [0:63][31:0] c_k = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] c_iv = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Eight independent 32-bit sums; carries never cross word boundaries.
    function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
// ============================================================================
// Module      : sha256_round
// Description : One combinational SHA-256 round on packed A..H state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  word_t        i_k,
    input  word_t        i_w,
    output logic [255:0] o_state
);

    word_t w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    word_t w_ch, w_maj, w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_ch    = (w_e & w_f) ^ (~w_e & w_g);
    assign w_maj   = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    assign w_t1    = w_h + big_sigma1(w_e) + w_ch + i_k + i_w;
    assign w_t2    = big_sigma0(w_a) + w_maj;
    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

`default_nettype wire

// File: rtl/sha256_round_engine.sv
// ============================================================================
// Module      : sha256_round_engine
// Description : Iterative SHA-256 compression, ROUNDS_PER_CYCLE rounds/clock.
//               SHA256_FEEDFORWARD_EN adds the chaining value to the result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [255:0] hash_i,
    input  logic [511:0] block_i,
    output logic         v_o,
    input  logic         yumi_i,
    output logic [255:0] digest_o
);

    localparam logic [5:0] c_step = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] c_last = 6'(64 - ROUNDS_PER_CYCLE);

    state_t       r_state, w_next_state;
    logic [5:0]   r_cnt;
    logic [255:0] r_work;
    logic [255:0] r_digest;
    word_t        r_window [16];
    word_t        w_ext [16 + ROUNDS_PER_CYCLE];
    logic [255:0] w_final;
    logic [255:0] w_result;

`ifdef SHA256_FEEDFORWARD_EN
    logic [255:0] r_chain;
    assign w_result = add_words(w_final, r_chain);
`else
    assign w_result = w_final;
`endif

    // Window holds W[t..t+15]; extend by R words so every round of this
    // edge has its W and the window can slide by R.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_window[i];
        end
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            w_ext[16 + j] = small_sigma1(w_ext[14 + j]) + w_ext[9 + j]
                          + small_sigma0(w_ext[1 + j]) + w_ext[j];
        end
    end

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
        logic [255:0] w_in;
        logic [255:0] w_out;
        logic [5:0]   w_k_idx;

        if (i == 0) begin : g_first
            assign w_in = r_work;
        end else begin : g_next
            assign w_in = g_round[i-1].w_out;
        end

        assign w_k_idx = r_cnt + 6'(i);

        sha256_round u_round (
            .i_state (w_in),
            .i_k     (c_k[w_k_idx]),
            .i_w     (w_ext[i]),
            .o_state (w_out)
        );
    end

    assign w_final = g_round[ROUNDS_PER_CYCLE-1].w_out;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (v_i)             w_next_state = BUSY;
            BUSY:    if (r_cnt == c_last) w_next_state = DONE;
            DONE:    if (yumi_i)          w_next_state = IDLE;
            default:                      w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt    <= '0;
            r_work   <= '0;
            r_digest <= '0;
            for (int i = 0; i < 16; i++) begin
                r_window[i] <= '0;
            end
`ifdef SHA256_FEEDFORWARD_EN
            r_chain  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (v_i) begin
                        r_work <= hash_i;
                        r_cnt  <= '0;
                        for (int i = 0; i < 16; i++) begin
                            r_window[i] <= block_i[511 - 32*i -: 32];
                        end
`ifdef SHA256_FEEDFORWARD_EN
                        r_chain <= hash_i;
`endif
                    end
                end
                BUSY: begin
                    r_work <= w_final;
                    r_cnt  <= r_cnt + c_step;
                    for (int i = 0; i < 16; i++) begin
                        r_window[i] <= w_ext[i + ROUNDS_PER_CYCLE];
                    end
                    if (r_cnt == c_last) begin
                        r_digest <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = (r_state == IDLE);
    assign v_o      = (r_state == DONE);
    assign digest_o = r_digest;

endmodule

`default_nettype wire

// File: doc/sha256_round_engine.md
SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, SHA-256 rounds applied per clock (legal: 1, 2, 4, 8, 16; divides 64).
REQ-002 SHALL have ports clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have reset_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have v_i  input  1  hash_i/block_i valid.
REQ-005 SHALL have ready_o  output  1  engine can accept a block.
REQ-006 SHALL have hash_i  input  256  chaining value; word A = [255:224] ... word H = [31:0].
REQ-007 SHALL have block_i  input  512  message block; W0 = [511:480] ... W15 = [31:0].
REQ-008 SHALL have v_o  output  1  digest_o valid.
REQ-009 SHALL have yumi_i  input  1  consumer takes digest this cycle; legal only while v_o=1.
REQ-010 SHALL have digest_o  output  256  result, same word order as hash_i.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 IDLE: ready_o=1, v_o=0; v_i & ready_o latches hash_i into the working regs A-H and chaining reg, block_i into the 16-word schedule window, round counter := 0, -> BUSY.
REQ-013 BUSY: ready_o=0, v_o=0; each edge applies ROUNDS_PER_CYCLE consecutive rounds t..t+R-1 (T1 = H+Sigma1(E)+Ch(E,F,G)+K[t]+W[t], T2 = Sigma0(A)+Maj(A,B,C)), counter += R.
REQ-014 Schedule: W[t] for t<16 from the window; t>=16 computed as sigma1(W[t-2])+W[t-7]+sigma0(W[t-15])+W[t-16]; window shifts by R words per edge.
REQ-015 All additions SHALL be modulo 2^32; no carry leaves a 32-bit word.
REQ-016 Edge applying rounds 64-R..63 SHALL load digest_o and enter DONE; v_o first high exactly 64/R cycles after the accepting edge (R=1: 64; R=8: 8).
REQ-017 DONE: v_o=1, ready_o=0, digest_o held stable; yumi_i=1 -> IDLE, ready_o=1 on the next cycle.
REQ-018 yumi_i while v_o=0 SHALL be ignored; v_i while ready_o=0 SHALL be ignored (no queuing).
REQ-019 No accept in the cycle of the yumi_i handshake; minimum block-to-block period is 64/R+2 cycles.

Reset
REQ-020 reset_i=1 at any edge, including mid-BUSY or in DONE, SHALL force IDLE, abandon the block, and clear counter, working regs and digest_o to 0.
REQ-021 While and directly after reset: ready_o=1, v_o=0, digest_o=0.

Configuration
REQ-022 With SHA256_FEEDFORWARD_EN defined, digest_o SHALL be the word-wise mod-2^32 sum of the final A-H and the latched hash_i (full compression function, chainable).
REQ-023 Without SHA256_FEEDFORWARD_EN, digest_o SHALL be the raw final A-H; the chaining register and its adders SHALL be absent; latency unchanged.

Structure
REQ-024 Package sha256_pkg SHALL hold the 32-bit word typedef, FSM state enum, 64-entry K constant table, and the 256-bit standard IV constant.
REQ-025 One combinational sub-module sha256_round (one round: Ch, Maj, Sigma0, Sigma1, T1/T2, next A-H) SHALL be instantiated ROUNDS_PER_CYCLE times in a chain.

Verification
REQ-026 FEEDFORWARD_EN, R=1, IV + padded "abc" -> v_o after 64 cycles, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-027 FEEDFORWARD_EN, R=4, IV + padded empty message -> v_o after 16 cycles, digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-028 FEEDFORWARD_EN, two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", digest of block 1 fed as hash_i of block 2 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-029 Backpressure: yumi_i held 0 for 10 cycles in DONE -> v_o=1, digest_o unchanged, v_i pulses ignored; yumi_i=1 -> ready_o=1 next cycle.
REQ-030 reset_i pulsed at round 20 -> next cycle ready_o=1, v_o=0, digest_o=0; fresh "abc" block then yields the REQ-026 digest.
REQ-031 Without SHA256_FEEDFORWARD_EN, "abc" -> digest equals REQ-026 value minus IV word-wise mod 2^32.
